wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Writeback-side consumer of the MEM/WB pipeline register: the register file plus HI/LO.
//   Takes the registered writeback enables, destination and data from MEM/WB.
//   Commits them on the clock edge and serves the decode stage with two async GPR read ports and HI/LO outputs.
//   Also keeps a count of committed GPR writes, used for bring-up and debug.
// PARAMETERS
//   DATA_W    32  width of GPRs, HI, LO and writeback data
//   ADDR_W    5   GPR index width (2**ADDR_W registers)
//   LINK_REG  31  GPR written by link_enable (jal/jalr return address)
//   CNT_W     32  width of write_count
// PORTS
//   clk          in   1       clock, rising edge
//   reset        in   1       asynchronous, active-high
//   rf_enable    in   1       commit wb_data to GPR[wb_rd]
//   link_enable  in   1       commit wb_data to GPR[LINK_REG]
//   hi_enable    in   1       commit wb_hi_data to HI
//   lo_enable    in   1       commit wb_lo_data to LO
//   wb_rd        in   ADDR_W  destination GPR index
//   wb_data      in   DATA_W  GPR writeback data (ALU/memory/link mux output)
//   wb_hi_data   in   DATA_W  HI writeback data
//   wb_lo_data   in   DATA_W  LO writeback data
//   rd_addr_a    in   ADDR_W  read port A index (rs)
//   rd_addr_b    in   ADDR_W  read port B index (rt)
//   rd_data_a    out  DATA_W  GPR[rd_addr_a], combinational
//   rd_data_b    out  DATA_W  GPR[rd_addr_b], combinational
//   hi_out       out  DATA_W  HI contents
//   lo_out       out  DATA_W  LO contents
//   write_count  out  CNT_W   number of committed GPR writes
// BEHAVIOUR
//   Reset
//   - Reset is asynchronous and dominant.
//   - It clears all GPRs, HI, LO and write_count to 0.
//   - Any write pending in the cycle reset is asserted is discarded.
//   - While reset is held, rd_data_a, rd_data_b, hi_out and lo_out read 0.
//   Writes: one per target per rising clk edge; latency 1 cycle.
//   - The effective GPR target is LINK_REG if link_enable=1.
//   - Otherwise the target is wb_rd if rf_enable=1.
//   - Otherwise no GPR write happens.
//   - link_enable has priority. With link_enable=1 and rf_enable=1, only LINK_REG is written; wb_rd is ignored.
//   - GPR 0 is hardwired: writes to index 0 are dropped, and reads of index 0 always return 0.
//   - HI and LO write independently of each other and of the GPR write. All three may commit on the same edge.
//   Counter
//   - write_count increments by 1 on each edge where a GPR write actually commits (target != 0).
//   - A dropped write to index 0 does not count; HI/LO writes do not count.
//   - The counter wraps from 2**CNT_W-1 to 0.
//   Reads
//   - Reads are purely combinational from storage; there is no read latency.
//   - Both read ports may address the same register.
// CONFIGURATION
//   WB_BYPASS_EN
//   - Defined: write-through bypass.
//     - If a GPR write commits this cycle and rd_addr_a or rd_addr_b equals the effective target (nonzero), that port returns wb_data in the same cycle.
//     - hi_out and lo_out likewise return wb_hi_data / wb_lo_data while hi_enable / lo_enable is 1.
//     - Index 0 is never bypassed.
//   - Undefined: reads return the stored value.
//     - A same-cycle read of the target returns the old value; the new value is visible the cycle after the edge.
// TESTING
//   1. Reset
//      - Stimulus: assert reset mid-run after GPR5=0x1234 is written.
//      - Expect: all reads 0, hi_out/lo_out 0, write_count 0, with no clock edge needed.
//   2. Basic write
//      - Stimulus: rf_enable=1, wb_rd=5, wb_data=0xDEADBEEF; one edge; rd_addr_a=5.
//      - Expect: rd_data_a=0xDEADBEEF, write_count=1.
//   3. Write to GPR 0
//      - Stimulus: rf_enable=1, wb_rd=0, wb_data=0xFFFFFFFF.
//      - Expect: rd_data_b(addr 0)=0, write_count unchanged.
//   4. Link priority
//      - Stimulus: link_enable=1, rf_enable=1, wb_rd=7, wb_data=0x00400008.
//      - Expect: GPR31=0x00400008, GPR7 unchanged, write_count +1.
//   5. HI/LO with GPR write
//      - Stimulus: hi_enable=lo_enable=1, hi=0x1, lo=0x2, plus rf write GPR3=0x3 on the same edge.
//      - Expect: hi_out=1, lo_out=2, GPR3=3.
//   6. Same-cycle read of write target
//      - Stimulus: write GPR9=0xA5A5A5A5 while rd_addr_a=9, before the edge.
//      - Expect with WB_BYPASS_EN: 0xA5A5A5A5.
//      - Expect without: old value, then 0xA5A5A5A5 after the edge.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback register file: 2**ADDR_W GPRs (GPR0 hardwired to zero), HI/LO, and a committed-write counter.
// Optional feature macro: WB_BYPASS_EN (same-cycle write-through bypass on all read outputs).
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_enable,
  input  logic              link_enable,
  input  logic              hi_enable,
  input  logic              lo_enable,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_hi_data,
  input  logic [DATA_W-1:0] wb_lo_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic [CNT_W-1:0]  write_count
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr_r [0:NREGS-1];
  logic [DATA_W-1:0] hi_r;
  logic [DATA_W-1:0] lo_r;
  logic [CNT_W-1:0]  write_count_r;
  logic [ADDR_W-1:0] target_s;
  logic              commit_s;

  // Resolve the effective GPR target; link wins over rf, and index 0 never commits.
  always_comb begin
    target_s = '0;
    commit_s = 1'b0;
    if (link_enable) begin
      target_s = ADDR_W'(LINK_REG);
    end else if (rf_enable) begin
      target_s = wb_rd;
    end else begin
      target_s = '0;
    end
    commit_s = (link_enable || rf_enable) && (target_s != '0);
  end

  // Storage and counter commit; reset discards any write pending in that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpr_r         <= '{default: '0};
      hi_r          <= '0;
      lo_r          <= '0;
      write_count_r <= '0;
    end else begin
      if (commit_s) begin
        gpr_r[target_s] <= wb_data;
        write_count_r   <= write_count_r + CNT_W'(1);
      end
      if (hi_enable) begin
        hi_r <= wb_hi_data;
      end
      if (lo_enable) begin
        lo_r <= wb_lo_data;
      end
    end
  end

  // Read port A; bypass is suppressed under reset so reads stay zero while reset is held.
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
`ifdef WB_BYPASS_EN
    end else if (!reset && commit_s && (rd_addr_a == target_s)) begin
      rd_data_a = wb_data;
`endif
    end else begin
      rd_data_a = gpr_r[rd_addr_a];
    end
  end

  // Read port B, same structure as port A.
  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
`ifdef WB_BYPASS_EN
    end else if (!reset && commit_s && (rd_addr_b == target_s)) begin
      rd_data_b = wb_data;
`endif
    end else begin
      rd_data_b = gpr_r[rd_addr_b];
    end
  end

  // HI/LO outputs.
  always_comb begin
    hi_out = hi_r;
    lo_out = lo_r;
`ifdef WB_BYPASS_EN
    if (!reset && hi_enable) begin
      hi_out = wb_hi_data;
    end else begin
      hi_out = hi_r;
    end
    if (!reset && lo_enable) begin
      lo_out = wb_lo_data;
    end else begin
      lo_out = lo_r;
    end
`endif
  end

  assign write_count = write_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: reference model plus expected-value queue drained after each step.
// A narrow counter width is used so that counter wrap-around is reached quickly.
module tb_wb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rf_enable = 1'b0, link_enable = 1'b0, hi_enable = 1'b0, lo_enable = 1'b0;
  logic [AW-1:0] wb_rd = '0;
  logic [DW-1:0] wb_data = '0, wb_hi_data = '0, wb_lo_data = '0;
  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [DW-1:0] rd_data_a, rd_data_b, hi_out, lo_out;
  logic [CW-1:0] write_count;

  wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .LINK_REG(31), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rf_enable(rf_enable), .link_enable(link_enable),
    .hi_enable(hi_enable), .lo_enable(lo_enable),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_hi_data(wb_hi_data), .wb_lo_data(wb_lo_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .hi_out(hi_out), .lo_out(lo_out), .write_count(write_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    int            port;   // 0=A 1=B 2=HI 3=LO 4=count
    logic [AW-1:0] addr;
    logic [DW-1:0] exp;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] m_gpr [0:31];
  logic [DW-1:0] m_hi, m_lo;
  logic [CW-1:0] m_cnt;

  task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_hi  = '0;
    m_lo  = '0;
    m_cnt = '0;
  endtask

  task automatic expect_q(input string tag, input int port, input logic [AW-1:0] addr);
    exp_t e;
    e.tag  = tag;
    e.port = port;
    e.addr = addr;
    case (port)
      0, 1:    e.exp = (addr == 5'd0) ? 32'd0 : m_gpr[addr];
      2:       e.exp = m_hi;
      3:       e.exp = m_lo;
      default: e.exp = {{(DW-CW){1'b0}}, m_cnt};
    endcase
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t          e;
    logic [DW-1:0] obs;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      @(negedge clk);
      if (e.port == 0) rd_addr_a = e.addr;
      if (e.port == 1) rd_addr_b = e.addr;
      #1;
      case (e.port)
        0:       obs = rd_data_a;
        1:       obs = rd_data_b;
        2:       obs = hi_out;
        3:       obs = lo_out;
        default: obs = {{(DW-CW){1'b0}}, write_count};
      endcase
      check_val(e.tag, obs, e.exp);
    end
  endtask

  // Reference behaviour of one commit edge.
  task automatic model_commit(input logic rf, input logic lnk, input logic hi, input logic lo,
                              input logic [AW-1:0] rd, input logic [DW-1:0] d,
                              input logic [DW-1:0] hd, input logic [DW-1:0] ld);
    logic [AW-1:0] tgt;
    logic          wr;
    wr  = lnk | rf;
    tgt = lnk ? 5'd31 : rd;
    if (wr && tgt != 5'd0) begin
      m_gpr[tgt] = d;
      m_cnt      = m_cnt + 4'd1;
    end
    if (hi) m_hi = hd;
    if (lo) m_lo = ld;
  endtask

  task automatic do_write(input logic rf, input logic lnk, input logic hi, input logic lo,
                          input logic [AW-1:0] rd, input logic [DW-1:0] d,
                          input logic [DW-1:0] hd, input logic [DW-1:0] ld);
    @(negedge clk);
    rf_enable = rf; link_enable = lnk; hi_enable = hi; lo_enable = lo;
    wb_rd = rd; wb_data = d; wb_hi_data = hd; wb_lo_data = ld;
    @(posedge clk);
    model_commit(rf, lnk, hi, lo, rd, d, hd, ld);
    #1;
    rf_enable = 1'b0; link_enable = 1'b0; hi_enable = 1'b0; lo_enable = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp6;
    model_reset();

    // Reset state, asynchronous: no edge has occurred yet.
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    #2;
    check_val("rst_a", rd_data_a, 32'd0);
    check_val("rst_b", rd_data_b, 32'd0);
    check_val("rst_hi", hi_out, 32'd0);
    check_val("rst_cnt", {{(DW-CW){1'b0}}, write_count}, 32'd0);
    #10;
    @(negedge clk);
    reset = 1'b0;

    // Mid-run reset after GPR5 and HI/LO hold data, with a write pending.
    do_write(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_00AA, 32'h0000_00BB);
    expect_q("pre_rst_g5", 0, 5'd5);
    expect_q("pre_rst_hi", 2, 5'd0);
    drain();
    @(negedge clk);
    #2;
    rd_addr_a = 5'd5;
    rf_enable = 1'b1; wb_rd = 5'd6; wb_data = 32'h0000_0066;
    reset = 1'b1;
    #1;
    check_val("mid_rst_g5", rd_data_a, 32'd0);
    check_val("mid_rst_hi", hi_out, 32'd0);
    check_val("mid_rst_lo", lo_out, 32'd0);
    check_val("mid_rst_cnt", {{(DW-CW){1'b0}}, write_count}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rf_enable = 1'b0;
    reset = 1'b0;
    model_reset();
    expect_q("rst_discard_g6", 0, 5'd6);
    expect_q("rst_cnt_after", 4, 5'd0);
    drain();

    // Basic write.
    do_write(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'd0, 32'd0);
    expect_q("basic_g5", 0, 5'd5);
    expect_q("basic_cnt", 4, 5'd0);
    drain();

    // Write to GPR0 is dropped and not counted.
    do_write(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    expect_q("g0_b", 1, 5'd0);
    expect_q("g0_cnt", 4, 5'd0);
    drain();

    // Link priority over rf.
    do_write(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h0000_0077, 32'd0, 32'd0);
    do_write(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 32'h0040_0008, 32'd0, 32'd0);
    expect_q("link_g31", 0, 5'd31);
    expect_q("link_g7", 1, 5'd7);
    expect_q("link_cnt", 4, 5'd0);
    drain();

    // HI, LO and GPR on the same edge.
    do_write(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002);
    expect_q("hl_hi", 2, 5'd0);
    expect_q("hl_lo", 3, 5'd0);
    expect_q("hl_g3", 0, 5'd3);
    expect_q("hl_g3b", 1, 5'd3);
    drain();

    // Same-cycle read of the write target.
    do_write(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_0011, 32'd0, 32'd0);
    @(negedge clk);
    rd_addr_a = 5'd9;
    rf_enable = 1'b1; wb_rd = 5'd9; wb_data = 32'hA5A5_A5A5;
    #1;
`ifdef WB_BYPASS_EN
    exp6 = 32'hA5A5_A5A5;
`else
    exp6 = m_gpr[9];
`endif
    check_val("same_cyc_g9", rd_data_a, exp6);
    @(posedge clk);
    model_commit(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'hA5A5_A5A5, 32'd0, 32'd0);
    #1;
    rf_enable = 1'b0;
    expect_q("after_edge_g9", 0, 5'd9);
    drain();

    // Random mix of enables, targets and data.
    for (int k = 0; k < 40; k++) begin
      do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
      expect_q("rnd_a", 0, 5'($urandom_range(0, 31)));
      expect_q("rnd_b", 1, 5'($urandom_range(0, 31)));
      expect_q("rnd_hi", 2, 5'd0);
      expect_q("rnd_lo", 3, 5'd0);
      expect_q("rnd_cnt", 4, 5'd0);
      drain();
    end

    // Counter wrap from all-ones to zero.
    for (int k = 0; k < 16 && m_cnt != 4'hF; k++) begin
      do_write(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'(k), 32'd0, 32'd0);
    end
    expect_q("cnt_max", 4, 5'd0);
    drain();
    do_write(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 32'h0000_0022, 32'd0, 32'd0);
    expect_q("cnt_wrap", 4, 5'd0);
    expect_q("wrap_g2", 1, 5'd2);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
